// File: rtl/inst_sequencer.sv
// inst_sequencer
// ---------------------------------------------------------------------------
// Consumer end of the instruction buffer fetch interface. A run primes the
// buffer with a jump fetch, then fetches one 128-bit instruction at a time,
// decodes its opcode and either retires it locally (NOP), ends the run (HALT)
// or hands it to the execution datapath over a valid/ready handshake. The
// next fetch is only requested after the execution unit reports completion.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start, abort       host run control (start sampled only when idle)
//   cfg_mode, cfg_incr buffer configuration, latched at start
//   ib_en, ib_mode, ib_incr, ib_jmp, force_inst, flag
//                      instruction buffer controls
//   instruction, init_inst_pulse, complete_flag
//                      instruction buffer fetch response
//   exec_valid, exec_ready, exec_op, exec_payload, exec_done
//                      dispatch handshake towards the execution units
//   busy, done, error, inst_count
//                      run status back to the host
// ---------------------------------------------------------------------------
module inst_sequencer #(
    parameter int INST_BITS     = 128,
    parameter int OP_BITS       = 4,
    parameter int CNT_BITS      = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cfg_mode,
    input  logic                          cfg_incr,
    output logic                          ib_en,
    output logic                          ib_mode,
    output logic                          ib_incr,
    output logic                          ib_jmp,
    output logic                          force_inst,
    output logic                          flag,
    input  logic [INST_BITS-1:0]          instruction,
    input  logic                          init_inst_pulse,
    input  logic                          complete_flag,
    output logic                          exec_valid,
    input  logic                          exec_ready,
    output logic [OP_BITS-1:0]            exec_op,
    output logic [INST_BITS-OP_BITS-1:0]  exec_payload,
    input  logic                          exec_done,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [CNT_BITS-1:0]           inst_count
);

    localparam int WAIT_BITS = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(FETCH_TIMEOUT - 1);
    localparam logic [OP_BITS-1:0] OP_NOP  = '0;
    localparam logic [OP_BITS-1:0] OP_HALT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PRIME_WAIT,
        S_FETCH,
        S_FETCH_WAIT,
        S_DISPATCH,
        S_EXEC_WAIT,
        S_FINISH
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   mode_q;
    logic                   incr_q;
    logic [INST_BITS-1:0]   inst_q;
    logic                   last_flag;
    logic [WAIT_BITS-1:0]   wait_cnt;

    logic                   latch_cfg;
    logic                   capture;
    logic                   count_inc;
    logic                   set_error;
    logic                   wait_run;
    logic [OP_BITS-1:0]     live_op;

    assign live_op = instruction[INST_BITS-1 -: OP_BITS];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run datapath: latched configuration, captured instruction word, the
    // fetch wait counter, the retired-instruction counter and the sticky
    // timeout flag. All updates are gated by strobes from the FSM so that an
    // abort (which suppresses every strobe) leaves count and error untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= 1'b0;
            incr_q     <= 1'b0;
            inst_q     <= '0;
            last_flag  <= 1'b0;
            wait_cnt   <= '0;
            inst_count <= '0;
            error      <= 1'b0;
        end else begin
            wait_cnt <= wait_run ? wait_cnt + 1'b1 : '0;
            if (latch_cfg) begin
                mode_q     <= cfg_mode;
                incr_q     <= cfg_incr;
                inst_count <= '0;
                error      <= 1'b0;
            end
            if (capture) begin
                inst_q    <= instruction;
                last_flag <= complete_flag;
            end
            // Saturating count; retirement can't coincide with latch_cfg.
            if (count_inc && (inst_count != '1)) begin
                inst_count <= inst_count + 1'b1;
            end
            if (set_error) begin
                error <= 1'b1;
            end
        end
    end

    // Next-state and output decode. The decode in FETCH_WAIT uses the live
    // fetch response, which is the same word being captured that cycle.
    always_comb begin
        state_next = state;
        latch_cfg  = 1'b0;
        capture    = 1'b0;
        count_inc  = 1'b0;
        set_error  = 1'b0;
        wait_run   = 1'b0;

        busy       = (state != S_IDLE);
        ib_en      = (state != S_IDLE) && (state != S_FINISH);
        force_inst = (state == S_PRIME);
        ib_jmp     = (state == S_PRIME);
        flag       = (state == S_FETCH);
        exec_valid = (state == S_DISPATCH);
        done       = (state == S_FINISH);

        if (abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latch_cfg  = 1'b1;
                        state_next = S_PRIME;
                    end
                end
                S_PRIME: begin
                    state_next = S_PRIME_WAIT;
                end
                S_PRIME_WAIT: begin
                    // Jump response carries the pre-jump address: discard it.
                    if (init_inst_pulse) begin
                        state_next = S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        set_error  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        wait_run = 1'b1;
                    end
                end
                S_FETCH: begin
                    state_next = S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (init_inst_pulse) begin
                        capture = 1'b1;
                        if (live_op == OP_NOP) begin
                            count_inc  = 1'b1;
                            state_next = complete_flag ? S_FINISH : S_FETCH;
                        end else if (live_op == OP_HALT) begin
                            state_next = S_FINISH;
                        end else begin
                            state_next = S_DISPATCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        set_error  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        wait_run = 1'b1;
                    end
                end
                S_DISPATCH: begin
                    // A completion arriving with the accept skips EXEC_WAIT.
                    if (exec_ready) begin
                        if (exec_done) begin
                            count_inc  = 1'b1;
                            state_next = last_flag ? S_FINISH : S_FETCH;
                        end else begin
                            state_next = S_EXEC_WAIT;
                        end
                    end
                end
                S_EXEC_WAIT: begin
                    if (exec_done) begin
                        count_inc  = 1'b1;
                        state_next = last_flag ? S_FINISH : S_FETCH;
                    end
                end
                S_FINISH: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign ib_mode      = mode_q;
    assign ib_incr      = incr_q;
    assign exec_op      = inst_q[INST_BITS-1 -: OP_BITS];
    assign exec_payload = inst_q[INST_BITS-OP_BITS-1:0];

endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer
// Directed bench for inst_sequencer. A small behavioural instruction buffer
// and execution unit respond to the DUT at the falling edge; the main thread
// runs directed scenarios and compares against hand-computed values.
module tb_inst_sequencer;

    localparam int INST_BITS = 128;
    localparam int OP_BITS   = 4;
    localparam int CNT_BITS  = 16;
    localparam int IB_LAT    = 2;

    logic                          clk;
    logic                          reset;
    logic                          start;
    logic                          abort;
    logic                          cfg_mode;
    logic                          cfg_incr;
    logic                          ib_en;
    logic                          ib_mode;
    logic                          ib_incr;
    logic                          ib_jmp;
    logic                          force_inst;
    logic                          flag;
    logic [INST_BITS-1:0]          instruction;
    logic                          init_inst_pulse;
    logic                          complete_flag;
    logic                          exec_valid;
    logic                          exec_ready;
    logic [OP_BITS-1:0]            exec_op;
    logic [INST_BITS-OP_BITS-1:0]  exec_payload;
    logic                          exec_done;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [CNT_BITS-1:0]           inst_count;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Buffer / execution model state
    logic [INST_BITS-1:0] mem [4];
    int          last_addr  = 3;
    int          ib_addr    = 0;
    bit          withhold   = 0;
    int          resp_cnt   = 0;
    logic [INST_BITS-1:0] resp_word;
    logic        resp_cf;
    int          done_delay = 2;
    int          done_cnt   = 0;
    int          stall_cnt  = 0;
    bit          in_stall   = 0;
    logic [OP_BITS-1:0]           hold_op;
    logic [INST_BITS-OP_BITS-1:0] hold_pl;
    int          force_cnt     = 0;
    int          flag_cnt      = 0;
    int          xfer_cnt      = 0;
    int          valid_cycles  = 0;
    int          finish_pulses = 0;
    logic [OP_BITS-1:0] ops_log [$];

    inst_sequencer #(
        .INST_BITS(INST_BITS),
        .OP_BITS(OP_BITS),
        .CNT_BITS(CNT_BITS),
        .FETCH_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .cfg_mode(cfg_mode),
        .cfg_incr(cfg_incr),
        .ib_en(ib_en),
        .ib_mode(ib_mode),
        .ib_incr(ib_incr),
        .ib_jmp(ib_jmp),
        .force_inst(force_inst),
        .flag(flag),
        .instruction(instruction),
        .init_inst_pulse(init_inst_pulse),
        .complete_flag(complete_flag),
        .exec_valid(exec_valid),
        .exec_ready(exec_ready),
        .exec_op(exec_op),
        .exec_payload(exec_payload),
        .exec_done(exec_done),
        .busy(busy),
        .done(done),
        .error(error),
        .inst_count(inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [INST_BITS-1:0] mkWord(input logic [3:0] op,
                                                    input logic [31:0] pl);
        mkWord = {op, 92'h0, pl};
    endfunction

    // Pulse start for one cycle; returns at the falling edge of PRIME.
    task automatic applyStimulus(input logic mode, input logic incr);
        @(negedge clk);
        cfg_mode = mode;
        cfg_incr = incr;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput("run_end_busy", {127'h0, busy}, 128'h0);
    endtask

    task automatic clearStats();
        force_cnt     = 0;
        flag_cnt      = 0;
        xfer_cnt      = 0;
        valid_cycles  = 0;
        finish_pulses = 0;
        ops_log.delete();
    endtask

    // Behavioural instruction buffer and execution unit.
    initial begin
        init_inst_pulse = 1'b0;
        instruction     = '0;
        complete_flag   = 1'b0;
        exec_ready      = 1'b1;
        exec_done       = 1'b0;
        resp_word       = '0;
        resp_cf         = 1'b0;
        hold_op         = '0;
        hold_pl         = '0;
        forever begin
            @(negedge clk);
            if (done) finish_pulses++;
            init_inst_pulse = 1'b0;
            complete_flag   = 1'b0;
            if (reset || !ib_en) begin
                resp_cnt = 0;
            end else begin
                if (resp_cnt != 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0 && !withhold) begin
                        init_inst_pulse = 1'b1;
                        instruction     = resp_word;
                        complete_flag   = resp_cf;
                    end
                end
                if (force_inst) begin
                    force_cnt++;
                    resp_word = mkWord(4'hF, 32'hDEAD_BEEF);
                    resp_cf   = 1'b0;
                    resp_cnt  = IB_LAT;
                    ib_addr   = 0;
                end else if (flag) begin
                    flag_cnt++;
                    resp_word = mem[ib_addr];
                    resp_cf   = !ib_mode && (ib_addr == last_addr);
                    resp_cnt  = IB_LAT;
                    ib_addr   = (ib_mode && ib_addr == last_addr) ? 0 : ib_addr + 1;
                end
            end
            exec_done = 1'b0;
            if (reset || !busy) begin
                done_cnt = 0;
            end else if (done_cnt != 0) begin
                done_cnt--;
                if (done_cnt == 0) exec_done = 1'b1;
            end
            if (exec_valid && !reset) begin
                valid_cycles++;
                if (stall_cnt != 0) begin
                    exec_ready = 1'b0;
                    stall_cnt--;
                    if (!in_stall) begin
                        hold_op  = exec_op;
                        hold_pl  = exec_payload;
                        in_stall = 1'b1;
                    end else begin
                        checkOutput("stall_op", {124'h0, exec_op}, {124'h0, hold_op});
                        checkOutput("stall_payload", {4'h0, exec_payload}, {4'h0, hold_pl});
                    end
                end else begin
                    exec_ready = 1'b1;
                    if (in_stall) begin
                        checkOutput("stall_op", {124'h0, exec_op}, {124'h0, hold_op});
                        checkOutput("stall_payload", {4'h0, exec_payload}, {4'h0, hold_pl});
                    end
                    in_stall = 1'b0;
                    xfer_cnt++;
                    ops_log.push_back(exec_op);
                    done_cnt = done_delay;
                end
            end else begin
                exec_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_ops [3];
        int cycles;
        int force_before;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_mode = 1'b0;
        cfg_incr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl",
                    {116'h0, busy, ib_en, ib_mode, ib_incr, ib_jmp, force_inst,
                     flag, exec_valid, done, error, exec_op == 4'h0, inst_count == 16'h0},
                    {116'h0, 12'b0000_0000_0011});
        reset = 1'b0;

        // Procedural run: op1, op2, NOP, op3.
        $display("[TB] procedural run");
        mem[0] = mkWord(4'h1, 32'h0000_00A1);
        mem[1] = mkWord(4'h2, 32'h0000_00A2);
        mem[2] = mkWord(4'h0, 32'h0);
        mem[3] = mkWord(4'h3, 32'h0000_00A3);
        last_addr = 3;
        done_delay = 2;
        clearStats();
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_busy", {127'h0, busy}, 128'h1);
        checkOutput("t1_incr", {127'h0, ib_incr}, 128'h1);
        waitIdle(300);
        exp_ops[0] = 4'h1; exp_ops[1] = 4'h2; exp_ops[2] = 4'h3;
        checkOutput("t1_nops", ops_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (ops_log.size() > i) checkOutput("t1_op", {124'h0, ops_log[i]}, {124'h0, exp_ops[i]});
        end
        checkOutput("t1_count", {112'h0, inst_count}, 128'd4);
        checkOutput("t1_done", finish_pulses, 1);
        checkOutput("t1_force", force_cnt, 1);
        checkOutput("t1_flag", flag_cnt, 4);
        checkOutput("t1_ib_en", {127'h0, ib_en}, 128'h0);

        // HALT at address 1.
        $display("[TB] halt run");
        mem[0] = mkWord(4'h5, 32'h0000_00B5);
        mem[1] = mkWord(4'hF, 32'h0);
        clearStats();
        applyStimulus(1'b0, 1'b1);
        waitIdle(300);
        checkOutput("t2_nops", ops_log.size(), 1);
        if (ops_log.size() > 0) checkOutput("t2_op", {124'h0, ops_log[0]}, 128'h5);
        checkOutput("t2_count", {112'h0, inst_count}, 128'd1);
        checkOutput("t2_done", finish_pulses, 1);
        checkOutput("t2_flag", flag_cnt, 2);

        // Backpressure: exec_ready low for 5 dispatch cycles.
        $display("[TB] stall run");
        mem[0] = mkWord(4'h7, 32'hCAFE_0007);
        last_addr = 0;
        clearStats();
        stall_cnt = 5;
        applyStimulus(1'b0, 1'b1);
        waitIdle(300);
        checkOutput("t3_xfer", xfer_cnt, 1);
        checkOutput("t3_valid_cycles", valid_cycles, 6);
        if (ops_log.size() > 0) checkOutput("t3_op", {124'h0, ops_log[0]}, 128'h7);
        checkOutput("t3_count", {112'h0, inst_count}, 128'd1);
        checkOutput("t3_done", finish_pulses, 1);

        // Wrap mode over addresses 0..1, abort after 6 retired.
        $display("[TB] wrap and abort run");
        mem[0] = mkWord(4'h1, 32'h0000_00C1);
        mem[1] = mkWord(4'h0, 32'h0);
        last_addr = 1;
        clearStats();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if (inst_count == 16'd6) break;
            @(negedge clk);
        end
        checkOutput("t4_reach6", {112'h0, inst_count}, 128'd6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t4_busy", {127'h0, busy}, 128'h0);
        checkOutput("t4_ib_en", {127'h0, ib_en}, 128'h0);
        checkOutput("t4_valid", {127'h0, exec_valid}, 128'h0);
        checkOutput("t4_count", {112'h0, inst_count}, 128'd6);
        checkOutput("t4_error", {127'h0, error}, 128'h0);
        checkOutput("t4_done", finish_pulses, 0);

        // Fetch timeout with responses withheld, then a clean restart.
        $display("[TB] timeout run");
        withhold = 1;
        clearStats();
        applyStimulus(1'b0, 1'b1);
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("t5_busy_cycles", cycles, 9);
        checkOutput("t5_error", {127'h0, error}, 128'h1);
        checkOutput("t5_busy", {127'h0, busy}, 128'h0);
        checkOutput("t5_done", finish_pulses, 0);
        withhold = 0;
        mem[0] = mkWord(4'h7, 32'hCAFE_0017);
        last_addr = 0;
        clearStats();
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_error_clear", {127'h0, error}, 128'h0);
        waitIdle(300);
        checkOutput("t5_rerun_done", finish_pulses, 1);
        checkOutput("t5_rerun_count", {112'h0, inst_count}, 128'd1);

        // Reset while waiting for execution completion.
        $display("[TB] reset mid-run");
        mem[0] = mkWord(4'h9, 32'h0000_00D9);
        done_delay = 20;
        clearStats();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (xfer_cnt != 0) break;
            @(negedge clk);
        end
        checkOutput("t6_xfer", xfer_cnt, 1);
        @(negedge clk);
        checkOutput("t6_pre_mode", {127'h0, ib_mode}, 128'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_ctrl_zero",
                    {112'h0, busy, ib_en, ib_mode, ib_incr, ib_jmp, force_inst,
                     flag, exec_valid, done, error, exec_op, 2'b00},
                    128'h0);
        checkOutput("t6_payload_zero", {4'h0, exec_payload}, 128'h0);
        checkOutput("t6_count_zero", {112'h0, inst_count}, 128'h0);
        reset = 1'b0;
        checkOutput("t6_done_none", finish_pulses, 0);
        done_delay = 2;
        force_before = force_cnt;
        clearStats();
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_prime_force", {127'h0, force_inst}, 128'h1);
        waitIdle(300);
        if (ops_log.size() > 0) checkOutput("t6_op", {124'h0, ops_log[0]}, 128'h9);
        checkOutput("t6_force", force_cnt, 1);
        checkOutput("t6_done", finish_pulses, 1);
        checkOutput("t6_count", {112'h0, inst_count}, 128'd1);
        if (force_before < 0) $display("[TB] note: force count %0d", force_before);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
